// File: rtl/mem_ctrl_pkg.sv
// Shared widths, FSM encoding and width-code decoding for the byte-serial memory controller.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned WSEL_W = 2;

  localparam logic [WSEL_W-1:0] WIDTH_BYTE = 2'b00;
  localparam logic [WSEL_W-1:0] WIDTH_HALF = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10
  } state_e;

  // Number of bytes moved for a width code; 10 and 11 both mean a full word.
  function automatic logic [CNT_W-1:0] width_bytes(input logic [WSEL_W-1:0] w);
    case (w)
      WIDTH_BYTE: width_bytes = CNT_W'(1);
      WIDTH_HALF: width_bytes = CNT_W'(2);
      default:    width_bytes = CNT_W'(4);
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Requester (IF + data) and byte-wide RAM port signals of the memory controller.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_clear;
  logic              if_done;
  logic [DATA_W-1:0] if_inst;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WSEL_W-1:0] mem_width;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;

  logic [BYTE_W-1:0] ram_din;
  logic [BYTE_W-1:0] ram_dout;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;

  modport slave (
    input  if_req, if_addr, if_clear, mem_req, mem_we, mem_addr, mem_width, mem_wdata, ram_din,
    output if_done, if_inst, mem_done, mem_rdata, ram_dout, ram_a, ram_wr
  );

  modport master (
    output if_req, if_addr, if_clear, mem_req, mem_we, mem_addr, mem_width, mem_wdata, ram_din,
    input  if_done, if_inst, mem_done, mem_rdata, ram_dout, ram_a, ram_wr
  );

endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates instruction fetch and data requests onto one byte-wide synchronous RAM port,
// sequencing 1/2/4-byte little-endian transfers with a single FSM and byte counter.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  mem_ctrl_if.slave   bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  nbytes_q, nbytes_d;
  logic              is_if_q, is_if_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0] if_inst_q, if_inst_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [BYTE_W-1:0] ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;

  logic [CNT_W-1:0]  step;
  logic [CNT_W-1:0]  req_bytes;
  logic [1:0]        cap_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      nbytes_q    <= '0;
      is_if_q     <= 1'b0;
      wdata_q     <= '0;
      buf_q       <= '0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nbytes_q    <= nbytes_d;
      is_if_q     <= is_if_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

  // Edge k after the grant sees step = k; RAM data for byte k-2 is on ram_din at that edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nbytes_d    = nbytes_q;
    is_if_d     = is_if_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = ram_wr_q;
    if_done_d   = if_done_q;
    mem_done_d  = mem_done_q;
    step        = CNT_W'(cnt_q + CNT_W'(1));
    req_bytes   = width_bytes(bus.mem_width);
    cap_idx     = 2'(step - CNT_W'(2));

    if (rdy) begin
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
      ram_wr_d   = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.mem_req) begin
            is_if_d  = 1'b0;
            nbytes_d = req_bytes;
            cnt_d    = '0;
            ram_a_d  = bus.mem_addr;
            if (bus.mem_we) begin
              ram_wr_d   = 1'b1;
              ram_dout_d = bus.mem_wdata[BYTE_W-1:0];
              wdata_d    = bus.mem_wdata >> BYTE_W;
              if (req_bytes == CNT_W'(1)) mem_done_d = 1'b1;
              else                        state_d    = ST_WRITE;
            end else begin
              buf_d   = '0;
              state_d = ST_READ;
            end
          end else if (bus.if_req && !bus.if_clear) begin
            is_if_d  = 1'b1;
            nbytes_d = CNT_W'(4);
            cnt_d    = '0;
            ram_a_d  = bus.if_addr;
            buf_d    = '0;
            state_d  = ST_READ;
          end
        end
        ST_READ: begin
          if (is_if_q && bus.if_clear) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = step;
            if (step < nbytes_q) ram_a_d = ram_a_q + ADDR_W'(1);
            if (step >= CNT_W'(2)) buf_d[BYTE_W*cap_idx +: BYTE_W] = bus.ram_din;
            if (step == CNT_W'(nbytes_q + CNT_W'(1))) begin
              cnt_d   = '0;
              state_d = ST_IDLE;
              if (is_if_q) begin
                if_inst_d = buf_d;
                if_done_d = 1'b1;
              end else begin
                mem_rdata_d = buf_d;
                mem_done_d  = 1'b1;
              end
            end
          end
        end
        ST_WRITE: begin
          cnt_d      = step;
          ram_a_d    = ram_a_q + ADDR_W'(1);
          ram_wr_d   = 1'b1;
          ram_dout_d = wdata_q[BYTE_W-1:0];
          wdata_d    = wdata_q >> BYTE_W;
          if (step == CNT_W'(nbytes_q - CNT_W'(1))) begin
            mem_done_d = 1'b1;
            cnt_d      = '0;
            state_d    = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A pause must silence writes and done pulses in the very cycle rdy drops.
  assign bus.if_done   = if_done_q & rdy;
  assign bus.mem_done  = mem_done_q & rdy;
  assign bus.ram_wr    = ram_wr_q & rdy;
  assign bus.if_inst   = if_inst_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.ram_a     = ram_a_q;
  assign bus.ram_dout  = ram_dout_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scenario bench for mem_ctrl with a byte-wide synchronous RAM model and a load-result scoreboard.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  always #5 clk = ~clk;

  mem_ctrl_if bus();

  mem_ctrl dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));

  logic [7:0]  ram [0:65535];
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_mem_q[$];
  logic [31:0] a_trace[$];
  logic [39:0] wr_log[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // RAM only advances while the system runs, so ram_din is stable during a pause.
  always @(posedge clk) begin
    if (rdy) begin
      if (bus.ram_wr) ram[bus.ram_a[15:0]] <= bus.ram_dout;
      bus.ram_din <= ram[bus.ram_a[15:0]];
    end
  end

  always @(posedge clk) begin
    if (bus.ram_wr === 1'b1) wr_log.push_back({bus.ram_a, bus.ram_dout});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ai;
      ai = a + 32'(i);
      ram[ai[15:0]] = w[8*i +: 8];
    end
  endtask

  task automatic mem_op(input logic we, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
    bus.mem_we    = we;
    bus.mem_width = w;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    bus.mem_req   = 1'b1;
  endtask

  // Ticks from the grant edge (c=0) until the selected done pulse; lat=-1 on timeout.
  task automatic wait_done(input bit is_if, input int budget, output int lat);
    lat = -1;
    for (int c = 0; c <= budget; c++) begin
      tick();
      a_trace.push_back(bus.ram_a);
      if (is_if ? bus.if_done : bus.mem_done) begin
        lat = c;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1;
    bus.if_req = 0; bus.if_addr = 0; bus.if_clear = 0;
    bus.mem_req = 0; bus.mem_we = 0; bus.mem_addr = 0; bus.mem_width = 0; bus.mem_wdata = 0;
    #2 rst = 1'b0;
    #1;
    n_checks++; if (bus.if_done !== 1'b0)     begin n_fail++; $display("FAIL reset_if_done: got %b want 0", bus.if_done); end
    n_checks++; if (bus.mem_done !== 1'b0)    begin n_fail++; $display("FAIL reset_mem_done: got %b want 0", bus.mem_done); end
    n_checks++; if (bus.if_inst !== 32'h0)    begin n_fail++; $display("FAIL reset_if_inst: got %h want 0", bus.if_inst); end
    n_checks++; if (bus.mem_rdata !== 32'h0)  begin n_fail++; $display("FAIL reset_mem_rdata: got %h want 0", bus.mem_rdata); end
    n_checks++; if (bus.ram_a !== 32'h0)      begin n_fail++; $display("FAIL reset_ram_a: got %h want 0", bus.ram_a); end
    n_checks++; if (bus.ram_dout !== 8'h0)    begin n_fail++; $display("FAIL reset_ram_dout: got %h want 0", bus.ram_dout); end
    n_checks++; if (bus.ram_wr !== 1'b0)      begin n_fail++; $display("FAIL reset_ram_wr: got %b want 0", bus.ram_wr); end
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic test_fetch();
    int lat;
    logic [31:0] e;
    exp_if_q.delete(); a_trace.delete();
    put_word(32'h100, 32'h0000_0513);
    exp_if_q.push_back(32'h0000_0513);
    bus.if_addr = 32'h100; bus.if_req = 1'b1;
    wait_done(1'b1, 20, lat);
    bus.if_req = 1'b0;
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL fetch_latency: got %0d want 5", lat); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (a_trace[i] !== 32'h100 + 32'(i)) begin n_fail++; $display("FAIL fetch_ram_a[%0d]: got %h want %h", i, a_trace[i], 32'h100 + 32'(i)); end
    end
    e = exp_if_q.pop_front();
    n_checks++; if (bus.if_inst !== e) begin n_fail++; $display("FAIL fetch_data: got %h want %h", bus.if_inst, e); end
  endtask

  task automatic test_arbitration();
    int mem_c, if_c;
    logic [31:0] e;
    exp_if_q.delete(); exp_mem_q.delete(); a_trace.delete();
    put_word(32'h0, 32'h4433_2211);
    put_word(32'h1000, 32'hD4C3_B2A1);
    exp_mem_q.push_back(32'hD4C3_B2A1);
    exp_if_q.push_back(32'h4433_2211);
    bus.if_addr = 32'h0; bus.if_req = 1'b1;
    mem_op(1'b0, 2'b10, 32'h1000, 32'h0);
    mem_c = -1; if_c = -1;
    for (int c = 0; c <= 30; c++) begin
      tick();
      a_trace.push_back(bus.ram_a);
      if (bus.mem_done) begin
        mem_c = c; bus.mem_req = 1'b0;
        e = exp_mem_q.pop_front();
        n_checks++; if (bus.mem_rdata !== e) begin n_fail++; $display("FAIL arb_mem_data: got %h want %h", bus.mem_rdata, e); end
      end
      if (bus.if_done) begin
        if_c = c; bus.if_req = 1'b0;
        e = exp_if_q.pop_front();
        n_checks++; if (bus.if_inst !== e) begin n_fail++; $display("FAIL arb_if_data: got %h want %h", bus.if_inst, e); end
        break;
      end
    end
    bus.if_req = 1'b0; bus.mem_req = 1'b0;
    n_checks++; if (mem_c !== 5)  begin n_fail++; $display("FAIL arb_mem_latency: got %0d want 5", mem_c); end
    n_checks++; if (if_c !== 11)  begin n_fail++; $display("FAIL arb_if_latency: got %0d want 11", if_c); end
    n_checks++; if (a_trace[5] !== 32'h1003) begin n_fail++; $display("FAIL arb_ram_a_mem_end: got %h want 00001003", a_trace[5]); end
    n_checks++; if (a_trace[6] !== 32'h0)    begin n_fail++; $display("FAIL arb_ram_a_if_start: got %h want 00000000", a_trace[6]); end
  endtask

  task automatic test_store();
    int lat;
    logic [31:0] e;
    exp_mem_q.delete(); wr_log.delete();
    mem_op(1'b1, 2'b01, 32'h2001, 32'hDEAD_BEEF);
    wait_done(1'b0, 10, lat);
    bus.mem_req = 1'b0;
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL sh_latency: got %0d want 1", lat); end
    n_checks++; if ({bus.ram_wr, bus.ram_a, bus.ram_dout} !== {1'b1, 32'h2002, 8'hBE})
      begin n_fail++; $display("FAIL sh_last_byte: got wr=%b a=%h d=%h want wr=1 a=00002002 d=be", bus.ram_wr, bus.ram_a, bus.ram_dout); end
    n_checks++; if (bus.mem_rdata !== 32'hD4C3_B2A1) begin n_fail++; $display("FAIL sh_rdata_kept: got %h want d4c3b2a1", bus.mem_rdata); end
    tick();
    n_checks++; if (bus.ram_wr !== 1'b0) begin n_fail++; $display("FAIL sh_wr_idle: got %b want 0", bus.ram_wr); end
    n_checks++; if (wr_log.size() !== 2) begin n_fail++; $display("FAIL sh_write_count: got %0d want 2", wr_log.size()); end
    n_checks++; if (wr_log[0] !== {32'h2001, 8'hEF}) begin n_fail++; $display("FAIL sh_write0: got %h want 00002001ef", wr_log[0]); end
    n_checks++; if (wr_log[1] !== {32'h2002, 8'hBE}) begin n_fail++; $display("FAIL sh_write1: got %h want 00002002be", wr_log[1]); end
    // Byte store completes in the grant cycle; the next load follows back to back.
    mem_op(1'b1, 2'b00, 32'h2003, 32'h1234_565A);
    wait_done(1'b0, 10, lat);
    bus.mem_req = 1'b0;
    n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL sb_latency: got %0d want 0", lat); end
    exp_mem_q.push_back(32'h0000_00BE);
    mem_op(1'b0, 2'b00, 32'h2002, 32'h0);
    wait_done(1'b0, 10, lat);
    bus.mem_req = 1'b0;
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL lb_latency: got %0d want 2", lat); end
    e = exp_mem_q.pop_front();
    n_checks++; if (bus.mem_rdata !== e) begin n_fail++; $display("FAIL lb_data: got %h want %h", bus.mem_rdata, e); end
    exp_mem_q.push_back(32'h0000_5ABE);
    mem_op(1'b0, 2'b01, 32'h2002, 32'h0);
    wait_done(1'b0, 10, lat);
    bus.mem_req = 1'b0;
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL lh_latency: got %0d want 3", lat); end
    e = exp_mem_q.pop_front();
    n_checks++; if (bus.mem_rdata !== e) begin n_fail++; $display("FAIL lh_data: got %h want %h", bus.mem_rdata, e); end
    tick();
  endtask

  task automatic test_wrap();
    int lat;
    logic [31:0] e;
    exp_mem_q.delete(); a_trace.delete();
    ram[16'hFFFE] = 8'h66; ram[16'hFFFF] = 8'h77;
    exp_mem_q.push_back(32'h2211_7766);
    mem_op(1'b0, 2'b11, 32'hFFFF_FFFE, 32'h0);
    wait_done(1'b0, 20, lat);
    bus.mem_req = 1'b0;
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL wrap_latency: got %0d want 5", lat); end
    n_checks++; if (a_trace[2] !== 32'h0) begin n_fail++; $display("FAIL wrap_ram_a: got %h want 00000000", a_trace[2]); end
    e = exp_mem_q.pop_front();
    n_checks++; if (bus.mem_rdata !== e) begin n_fail++; $display("FAIL wrap_data: got %h want %h", bus.mem_rdata, e); end
    tick();
  endtask

  task automatic test_pause();
    int lat;
    logic [31:0] e;
    exp_mem_q.delete(); wr_log.delete();
    exp_mem_q.push_back(32'hD4C3_B2A1);
    mem_op(1'b0, 2'b10, 32'h1000, 32'h0);
    lat = -1;
    for (int c = 0; c <= 30; c++) begin
      rdy = !(c >= 2 && c < 5);
      tick();
      if (bus.mem_done) begin lat = c; break; end
    end
    rdy = 1'b1; bus.mem_req = 1'b0;
    n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL pause_latency: got %0d want 8", lat); end
    n_checks++; if (wr_log.size() !== 0) begin n_fail++; $display("FAIL pause_writes: got %0d want 0", wr_log.size()); end
    e = exp_mem_q.pop_front();
    n_checks++; if (bus.mem_rdata !== e) begin n_fail++; $display("FAIL pause_data: got %h want %h", bus.mem_rdata, e); end
    tick();
  endtask

  task automatic test_clear();
    int lat, seen;
    logic [31:0] e;
    exp_if_q.delete();
    // Abort once mid-fetch and once on the edge that would have produced if_done.
    for (int k = 0; k < 2; k++) begin
      int clr_edge;
      clr_edge = (k == 0) ? 3 : 5;
      seen = 0;
      bus.if_addr = 32'h100; bus.if_req = 1'b1;
      for (int c = 0; c <= 10; c++) begin
        bus.if_clear = (c == clr_edge);
        tick();
        if (c == clr_edge) begin bus.if_req = 1'b0; bus.if_clear = 1'b0; end
        if (bus.if_done) seen++;
      end
      n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL clear%0d_done: got %0d pulses want 0", k, seen); end
      n_checks++; if (bus.if_inst !== 32'h4433_2211) begin n_fail++; $display("FAIL clear%0d_inst: got %h want 44332211", k, bus.if_inst); end
    end
    put_word(32'h200, 32'h8000_1237);
    exp_if_q.push_back(32'h8000_1237);
    bus.if_addr = 32'h200; bus.if_req = 1'b1;
    wait_done(1'b1, 20, lat);
    bus.if_req = 1'b0;
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL refetch_latency: got %0d want 5", lat); end
    e = exp_if_q.pop_front();
    n_checks++; if (bus.if_inst !== e) begin n_fail++; $display("FAIL refetch_data: got %h want %h", bus.if_inst, e); end
    tick();
  endtask

  task automatic test_reset_store();
    int seen;
    wr_log.delete();
    put_word(32'h3000, 32'h0);
    mem_op(1'b1, 2'b10, 32'h3000, 32'h1122_3344);
    tick(); tick();
    rst = 1'b0;
    #1;
    n_checks++; if ({bus.ram_wr, bus.ram_a, bus.ram_dout} !== 41'h0)
      begin n_fail++; $display("FAIL rst_port: got wr=%b a=%h d=%h want zeros", bus.ram_wr, bus.ram_a, bus.ram_dout); end
    n_checks++; if ({bus.if_inst, bus.mem_rdata} !== 64'h0)
      begin n_fail++; $display("FAIL rst_data: got inst=%h rdata=%h want zeros", bus.if_inst, bus.mem_rdata); end
    bus.mem_req = 1'b0;
    tick();
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.mem_done) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rst_no_done: got %0d pulses want 0", seen); end
    n_checks++; if (wr_log.size() !== 1) begin n_fail++; $display("FAIL rst_write_count: got %0d want 1", wr_log.size()); end
    n_checks++; if (wr_log[0] !== {32'h3000, 8'h44}) begin n_fail++; $display("FAIL rst_write0: got %h want 0000300044", wr_log[0]); end
    n_checks++; if (ram[16'h3001] !== 8'h00) begin n_fail++; $display("FAIL rst_ram_3001: got %h want 00", ram[16'h3001]); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_arbitration();
    test_store();
    test_wrap();
    test_pause();
    test_clear();
    test_reset_store();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
